ss_state_sequencer: RTL and testbench
=====================================

// Module: ss_state_sequencer
// PURPOSE
//  Save-state master sitting directly upstream of every RAM's ssbus slave port.
//  On save it walks slave indices 0..NUM_SLAVES-1 and reads each slave's words
//  out onto a 64-bit stream toward DDR. On restore it consumes the same stream
//  and writes the words back. Each slave is framed by a header word.
// PARAMETERS
//  NUM_SLAVES   16    number of SS_IDX slots scanned (0..NUM_SLAVES-1)
//  TIMEOUT      255   max cycles to wait for write_ack/read_response before error
//  FIFO_DEPTH   4     save-path output FIFO entries (power of 2, >=2)
// PORTS
//  clock         in   1   single system clock
//  reset_n       in   1   synchronous, active-low reset
//  start_save    in   1   1-cycle pulse; ignored unless idle
//  start_restore in   1   1-cycle pulse; ignored unless idle; save wins if both set
//  busy          out  1   high from accepted start until done/error
//  done          out  1   1-cycle pulse on successful completion
//  error         out  1   sticky until next accepted start
//  ssbus         -    -   ssbus_if.master: select idx, addr, data, read, write, ack, rdata, size, width
//  wr_data       out  64  save stream data
//  wr_valid      out  1   save stream valid
//  wr_ready      in   1   save stream ready (transfer when valid&ready)
//  rd_data       in   64  restore stream data
//  rd_valid      in   1   restore stream valid
//  rd_ready      out  1   restore stream ready
// BEHAVIOUR
//  Reset: busy=0, done=0, error=0, wr_valid=0, rd_ready=0, ssbus read/write=0, FIFO empty.
//  States: IDLE, QUERY, HDR, XFER, [CSUM], NEXT, FLUSH, DONE, ERR.
//  IDLE: on start latch mode, idx=0, clear error -> QUERY.
//  QUERY: drive select=idx, 2 cycles (select, then sample size/width).
//   size==0 -> NEXT (no header emitted/expected). Else -> HDR.
//  Header word = {16'h5353, idx[7:0], width[7:0], size[31:0]}.
//  HDR save: push header into FIFO (stall while full). HDR restore: pop one rd word;
//   magic, idx, width and size must match queried values, else -> ERR.
//  XFER: addr counts 0..size-1. Save: assert read; on ack push zero-extended rdata to
//   FIFO; one word in flight max; do not issue read while FIFO full.
//   Restore: pop rd word, drive data + write until ack; rd_ready high only when
//   no write outstanding. After addr==size-1 ack -> CSUM if enabled else NEXT.
//  Timeout: counter resets on each request, increments while waiting; reaching
//   TIMEOUT -> ERR. rd_valid/wr_ready stalls never time out.
//  NEXT: idx==NUM_SLAVES-1 -> FLUSH else idx+1 -> QUERY.
//  FLUSH: wait FIFO empty (save) -> DONE. DONE: pulse done 1 cycle -> IDLE.
//  ERR: drop read/write, flush FIFO without output, set error, busy=0 -> IDLE.
//  FIFO: full = count==FIFO_DEPTH; push and pop same cycle when full is legal.
//  Data wider than width bits truncated on write, zero-extended on read.
//  reset_n low mid-transfer: abort immediately, all outputs to reset values.
// CONFIGURATION
//  SS_SEQ_CHECKSUM_EN defined: after each slave's data an extra word
//   {32'h0, sum} where sum = 32-bit wraparound add of all 64-bit data words'
//   low 32 bits; save emits it, restore compares, mismatch -> ERR.
//  Undefined: no trailer word, no compare; stream format is header+data only.
// STRUCTURE
//  Package ss_seq_pkg: state enum, SS_MAGIC=16'h5353, header pack/unpack functions,
//   header field typedef struct.
//  Sub-module ss_seq_fifo (sync FIFO, 64-bit, FIFO_DEPTH) for the save path.
// TESTING
//  Save, slaves idx1 size 4 width 1 / idx3 size 2 width 0, others size 0 ->
//   stream: hdr(53530101_00000004),4 data,hdr(53530300_00000002),2 data; done pulse.
//  Restore same stream -> slave RAMs hold identical contents; done, error=0.
//  Restore with header idx=2 where idx1 expected -> error=1, busy=0, no writes after.
//  Slave never acks read at addr 0 -> error after exactly TIMEOUT wait cycles.
//  wr_ready held low 20 cycles mid-save -> at most FIFO_DEPTH words buffered,
//   no read issued while full, stream identical to unstalled run.
//  With SS_SEQ_CHECKSUM_EN, data 1,2,3,4 -> trailer 0x0000000A; corrupt one
//   restore word -> error=1.

Source files
------------

// File: rtl/ss_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ss_seq_pkg
//  Purpose  : Shared types and helpers for the save-state sequencer: FSM state
//             encoding, stream header layout and slave data-width masking.
//  Revision : 1.0 - initial release
// ============================================================================
package ss_seq_pkg;

    localparam logic [15:0] SS_MAGIC = 16'h5353;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_QUERY = 4'd1,
        ST_HDR   = 4'd2,
        ST_XFER  = 4'd3,
        ST_CSUM  = 4'd4,
        ST_NEXT  = 4'd5,
        ST_FLUSH = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } ss_state_e;

    // Per-slave framing word, most significant field first on the stream
    typedef struct packed {
        logic [15:0] magic;
        logic [7:0]  idx;
        logic [7:0]  width;
        logic [31:0] size;
    } ss_hdr_t;

    function automatic logic [63:0] pack_header(input logic [7:0]  idx,
                                                input logic [7:0]  width,
                                                input logic [31:0] size);
        ss_hdr_t h;
        h.magic = SS_MAGIC;
        h.idx   = idx;
        h.width = width;
        h.size  = size;
        return h;
    endfunction

    function automatic ss_hdr_t unpack_header(input logic [63:0] word);
        return ss_hdr_t'(word);
    endfunction

    // Slave width code selects the data lane size: 0=8b, 1=16b, 2=32b, else 64b
    function automatic logic [63:0] width_mask(input logic [7:0] width);
        case (width)
            8'd0:    return 64'h0000_0000_0000_00FF;
            8'd1:    return 64'h0000_0000_0000_FFFF;
            8'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_state_sequencer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ss_seq_fifo
//  Purpose  : Synchronous FIFO buffering the save stream. A push while full
//             is accepted when a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ss_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_FULL_COUNT);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush discards everything at once
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ss_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ss_state_sequencer
//  Purpose  : Save-state master. Save walks every slave index, emitting a
//             header plus the slave's words onto a 64-bit stream; restore
//             consumes the same stream and writes the words back.
//             Optional per-slave checksum trailer: define SS_SEQ_CHECKSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ss_state_sequencer
    import ss_seq_pkg::*;
#(
    parameter int NUM_SLAVES = 16,
    parameter int TIMEOUT    = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_save,
    input  logic        start_restore,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  ss_select,
    output logic [31:0] ss_addr,
    output logic [63:0] ss_data,
    output logic        ss_read,
    output logic        ss_write,
    input  logic        ss_ack,
    input  logic [63:0] ss_rdata,
    input  logic [31:0] ss_size,
    input  logic [7:0]  ss_width,
    output logic [63:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    input  logic [63:0] rd_data,
    input  logic        rd_valid,
    output logic        rd_ready
);

    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TLIM   = TW'(TIMEOUT - 1);
    localparam logic [7:0]  C_LAST_IDX = 8'(NUM_SLAVES - 1);
`ifdef SS_SEQ_CHECKSUM_EN
    localparam ss_state_e   C_AFTER_DATA = ST_CSUM;
`else
    localparam ss_state_e   C_AFTER_DATA = ST_NEXT;
`endif

    ss_state_e     r_state;
    logic          r_restore;
    logic          r_query_phase;
    logic [31:0]   r_size;
    logic [7:0]    r_width;
    logic [TW-1:0] r_timer;

    logic          w_push;
    logic [63:0]   w_push_data;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_flush;
    logic          w_can_push;
    logic [63:0]   w_mask;
    logic [63:0]   w_rd_masked;
    logic [63:0]   w_hdr_word;
    logic          w_last;
    logic          w_timed_out;
    logic          w_hdr_ok;
    ss_hdr_t       w_rx_hdr;

    assign w_mask      = width_mask(r_width);
    assign w_rd_masked = ss_rdata & w_mask;
    assign w_hdr_word  = pack_header(ss_select, r_width, r_size);
    assign w_last      = (ss_addr == r_size - 32'd1);
    assign w_timed_out = (r_timer == C_TLIM);
    assign w_rx_hdr    = unpack_header(rd_data);
    assign w_hdr_ok    = (w_rx_hdr.magic == SS_MAGIC) && (w_rx_hdr.idx == ss_select) &&
                         (w_rx_hdr.width == r_width) && (w_rx_hdr.size == r_size);

    // Abort discards buffered save data without letting it reach the stream
    assign w_flush    = (r_state == ST_ERR);
    assign wr_valid   = !w_empty && !w_flush;
    assign w_pop      = wr_valid && wr_ready;
    assign w_can_push = !w_full || wr_ready;

`ifdef SS_SEQ_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        w_save_beat;
    logic        w_restore_beat;

    assign w_save_beat    = (r_state == ST_XFER) && !r_restore && ss_read && ss_ack;
    assign w_restore_beat = (r_state == ST_XFER) && r_restore && !ss_write && rd_valid;

    // Running per-slave sum of the low 32 bits of each stream data word
    always_ff @(posedge clock) begin
        if (!reset_n || r_state == ST_QUERY) begin
            r_sum <= '0;
        end else if (w_save_beat) begin
            r_sum <= r_sum + w_rd_masked[31:0];
        end else if (w_restore_beat) begin
            r_sum <= r_sum + rd_data[31:0];
        end
    end
`endif

    // Save-path FIFO push source and restore-stream ready per state
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        rd_ready    = 1'b0;
        case (r_state)
            ST_HDR: begin
                if (r_restore) begin
                    rd_ready = 1'b1;
                end else begin
                    w_push      = w_can_push;
                    w_push_data = w_hdr_word;
                end
            end
            ST_XFER: begin
                if (r_restore) begin
                    rd_ready = !ss_write;
                end else begin
                    w_push      = ss_read && ss_ack;
                    w_push_data = w_rd_masked;
                end
            end
`ifdef SS_SEQ_CHECKSUM_EN
            ST_CSUM: begin
                if (r_restore) begin
                    rd_ready = 1'b1;
                end else begin
                    w_push      = w_can_push;
                    w_push_data = {32'h0, r_sum};
                end
            end
`endif
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    ss_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (wr_data),
        .empty     (w_empty),
        .full      (w_full)
    );

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_restore     <= 1'b0;
            r_query_phase <= 1'b0;
            r_size        <= '0;
            r_width       <= '0;
            r_timer       <= '0;
            ss_select     <= '0;
            ss_addr       <= '0;
            ss_data       <= '0;
            ss_read       <= 1'b0;
            ss_write      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_save || start_restore) begin
                        r_restore     <= !start_save;
                        ss_select     <= '0;
                        r_query_phase <= 1'b0;
                        error         <= 1'b0;
                        busy          <= 1'b1;
                        r_state       <= ST_QUERY;
                    end
                end
                ST_QUERY: begin
                    // First cycle presents the index, second samples its geometry
                    if (!r_query_phase) begin
                        r_query_phase <= 1'b1;
                    end else begin
                        r_query_phase <= 1'b0;
                        r_size        <= ss_size;
                        r_width       <= ss_width;
                        ss_addr       <= '0;
                        r_state       <= (ss_size == 32'd0) ? ST_NEXT : ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!r_restore) begin
                        if (w_can_push) begin
                            r_state <= ST_XFER;
                        end
                    end else if (rd_valid) begin
                        r_state <= w_hdr_ok ? ST_XFER : ST_ERR;
                    end
                end
                ST_XFER: begin
                    if (!r_restore) begin
                        // One read in flight; only issue with guaranteed FIFO room
                        if (!ss_read) begin
                            if (!w_full) begin
                                ss_read <= 1'b1;
                                r_timer <= '0;
                            end
                        end else if (ss_ack) begin
                            ss_read <= 1'b0;
                            if (w_last) begin
                                r_state <= C_AFTER_DATA;
                            end else begin
                                ss_addr <= ss_addr + 32'd1;
                            end
                        end else if (w_timed_out) begin
                            ss_read <= 1'b0;
                            r_state <= ST_ERR;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end else begin
                        if (!ss_write) begin
                            if (rd_valid) begin
                                ss_data  <= rd_data & w_mask;
                                ss_write <= 1'b1;
                                r_timer  <= '0;
                            end
                        end else if (ss_ack) begin
                            ss_write <= 1'b0;
                            if (w_last) begin
                                r_state <= C_AFTER_DATA;
                            end else begin
                                ss_addr <= ss_addr + 32'd1;
                            end
                        end else if (w_timed_out) begin
                            ss_write <= 1'b0;
                            r_state  <= ST_ERR;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                end
`ifdef SS_SEQ_CHECKSUM_EN
                ST_CSUM: begin
                    if (!r_restore) begin
                        if (w_can_push) begin
                            r_state <= ST_NEXT;
                        end
                    end else if (rd_valid) begin
                        r_state <= (rd_data == {32'h0, r_sum}) ? ST_NEXT : ST_ERR;
                    end
                end
`endif
                ST_NEXT: begin
                    if (ss_select == C_LAST_IDX) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        ss_select     <= ss_select + 8'd1;
                        r_query_phase <= 1'b0;
                        r_state       <= ST_QUERY;
                    end
                end
                ST_FLUSH: begin
                    if (r_restore || w_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    ss_read  <= 1'b0;
                    ss_write <= 1'b0;
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ss_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ss_state_sequencer
//  Purpose  : Self-checking bench for ss_state_sequencer: slave RAM models,
//             save/restore stream endpoints and a reference stream model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ss_state_sequencer;

    localparam int NS    = 16;
    localparam int TO    = 255;
    localparam int FD    = 4;
    localparam int MAXSZ = 8;

    logic        clock;
    logic        reset_n;
    logic        start_save;
    logic        start_restore;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  ss_select;
    logic [31:0] ss_addr;
    logic [63:0] ss_data;
    logic        ss_read;
    logic        ss_write;
    logic        ss_ack;
    logic [63:0] ss_rdata;
    logic [31:0] ss_size;
    logic [7:0]  ss_width;
    logic [63:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;

    logic [31:0] cfg_size  [NS];
    logic [7:0]  cfg_width [NS];
    logic [63:0] src     [NS][MAXSZ];
    logic [63:0] dst     [NS][MAXSZ];
    logic [63:0] exp_mem [NS][MAXSZ];
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] rdq[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  lat_cnt, lat_target, n_writes, to_cnt, hold_cnt, stall_reads, hold_seen;
    bit  rand_lat, rand_wr, rand_rd, block_addr0, stall_arm, op_done;

    ss_state_sequencer #(.NUM_SLAVES(NS), .TIMEOUT(TO), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset_n(reset_n), .start_save(start_save),
        .start_restore(start_restore), .busy(busy), .done(done), .error(error),
        .ss_select(ss_select), .ss_addr(ss_addr), .ss_data(ss_data),
        .ss_read(ss_read), .ss_write(ss_write), .ss_ack(ss_ack),
        .ss_rdata(ss_rdata), .ss_size(ss_size), .ss_width(ss_width),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    assign ss_size  = (ss_select < NS) ? cfg_size[ss_select[3:0]]  : 32'd0;
    assign ss_width = (ss_select < NS) ? cfg_width[ss_select[3:0]] : 8'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lane mask from the width code: 8 << code bits, capped at 64
    function automatic logic [63:0] mask_of(input logic [7:0] w);
        if (w >= 8'd3) return {64{1'b1}};
        return (64'd1 << (8 << w)) - 64'd1;
    endfunction

    // Reference stream and expected restored RAM contents from the config
    function automatic void build_expected();
        logic [63:0] word;
`ifdef SS_SEQ_CHECKSUM_EN
        logic [31:0] sum;
`endif
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            for (int a = 0; a < MAXSZ; a++) exp_mem[i][a] = 64'd0;
            if (cfg_size[i] != 0) begin
                exp_q.push_back((64'h5353 << 48) | (64'(i) << 40) |
                                (64'(cfg_width[i]) << 32) | 64'(cfg_size[i]));
`ifdef SS_SEQ_CHECKSUM_EN
                sum = 32'd0;
`endif
                for (int a = 0; a < int'(cfg_size[i]); a++) begin
                    word = src[i][a] & mask_of(cfg_width[i]);
                    exp_q.push_back(word);
                    exp_mem[i][a] = word;
`ifdef SS_SEQ_CHECKSUM_EN
                    sum = sum + word[31:0];
`endif
                end
`ifdef SS_SEQ_CHECKSUM_EN
                exp_q.push_back({32'h0, sum});
`endif
            end
        end
    endfunction

    // Advance to the next falling edge and play slave RAMs and stream ends
    task automatic tick();
        @(negedge clock);
        if (ss_read || ss_write) begin
            if (block_addr0 && ss_read && ss_addr == 32'd0) begin
                ss_ack = 1'b0;
                to_cnt++;
            end else if (lat_cnt >= lat_target) begin
                ss_ack = 1'b1;
                if (ss_read) begin
                    ss_rdata = src[ss_select[3:0]][ss_addr[2:0]];
                    if (hold_cnt > 0) stall_reads++;
                end else begin
                    dst[ss_select[3:0]][ss_addr[2:0]] = ss_data;
                    n_writes++;
                end
                lat_cnt    = 0;
                lat_target = rand_lat ? int'($urandom_range(0, 3)) : 0;
            end else begin
                ss_ack = 1'b0;
                lat_cnt++;
            end
        end else begin
            ss_ack  = 1'b0;
            lat_cnt = 0;
        end
        if (hold_cnt > 0) begin
            wr_ready = 1'b0;
            hold_cnt--;
            hold_seen++;
        end else begin
            wr_ready = rand_wr ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (wr_valid && wr_ready) begin
            got_q.push_back(wr_data);
            if (stall_arm && got_q.size() == 3) begin
                hold_cnt  = 20;
                stall_arm = 1'b0;
            end
        end
        rd_valid = (rdq.size() > 0) && (rand_rd ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (rd_valid) rd_data = rdq[0];
        if (rd_valid && rd_ready) rdq.delete(0);
    endtask

    task automatic run_op(input string tag, input bit restore, input bit both);
        tick();
        start_save    = !restore || both;
        start_restore = restore;
        tick();
        start_save    = 1'b0;
        start_restore = 1'b0;
        op_done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            tick();
            if (done) op_done = 1'b1;
            if (!busy) begin
                chk({tag, "_finished"}, 1, 1);
                return;
            end
        end
        chk({tag, "_finished"}, 0, 1);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NS; i++) begin
            cfg_size[i]  = 32'd0;
            cfg_width[i] = 8'd0;
            for (int a = 0; a < MAXSZ; a++) src[i][a] = {$urandom, $urandom};
        end
    endtask

    task automatic random_cfg();
        clear_cfg();
        for (int i = 0; i < NS; i++) begin
            if ($urandom_range(0, 2) == 0) cfg_size[i] = 32'($urandom_range(1, MAXSZ));
            cfg_width[i] = 8'($urandom_range(0, 3));
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
    endtask

    task automatic restore_and_check(input string tag);
        int total;
        total = 0;
        for (int i = 0; i < NS; i++) begin
            total += int'(cfg_size[i]);
            for (int a = 0; a < MAXSZ; a++) dst[i][a] = 64'd0;
        end
        rdq      = got_q;
        n_writes = 0;
        run_op(tag, 1'b1, 1'b0);
        chk({tag, "_done"}, 64'(op_done), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_nwrites"}, 64'(n_writes), 64'(total));
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < MAXSZ; a++)
                chk($sformatf("%s_mem%0d_%0d", tag, i, a), dst[i][a], exp_mem[i][a]);
        rdq.delete();
    endtask

    initial begin
        int hdr3_pos;
        reset_n = 1'b0; start_save = 1'b0; start_restore = 1'b0;
        ss_ack = 1'b0; ss_rdata = 64'd0; wr_ready = 1'b1;
        rd_data = 64'd0; rd_valid = 1'b0;
        lat_cnt = 0; lat_target = 0; n_writes = 0; to_cnt = 0;
        hold_cnt = 0; stall_reads = 0; hold_seen = 0;
        rand_lat = 1'b0; rand_wr = 1'b0; rand_rd = 1'b0;
        block_addr0 = 1'b0; stall_arm = 1'b0; op_done = 1'b0;
        clear_cfg();
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_read", 64'(ss_read), 64'd0);
        chk("rst_write", 64'(ss_write), 64'd0);
        reset_n = 1'b1;
        tick();

        // Directed save: idx1 size4 width1, idx3 size2 width0
        clear_cfg();
        cfg_size[1] = 32'd4; cfg_width[1] = 8'd1;
        cfg_size[3] = 32'd2; cfg_width[3] = 8'd0;
        build_expected();
        got_q.delete();
        run_op("save_dir", 1'b0, 1'b0);
        chk("save_dir_done", 64'(op_done), 64'd1);
        chk("save_dir_error", 64'(error), 64'd0);
        check_stream("save_dir");
`ifdef SS_SEQ_CHECKSUM_EN
        hdr3_pos = 6;
`else
        hdr3_pos = 5;
`endif
        chk("save_dir_hdr1", (got_q.size() > 0) ? got_q[0] : 64'hx, 64'h5353_0101_0000_0004);
        chk("save_dir_hdr3", (got_q.size() > hdr3_pos) ? got_q[hdr3_pos] : 64'hx,
            64'h5353_0300_0000_0002);

        // Restore the same stream
        restore_and_check("rest_dir");

        // Restore with a header naming idx2 where idx1 is expected
        rdq.delete();
        rdq.push_back(64'h5353_0201_0000_0004);
        for (int a = 0; a < 4; a++) rdq.push_back(64'(a + 1));
        n_writes = 0;
        run_op("bad_hdr", 1'b1, 1'b0);
        chk("bad_hdr_error", 64'(error), 64'd1);
        chk("bad_hdr_busy", 64'(busy), 64'd0);
        repeat (20) tick();
        chk("bad_hdr_nwrites", 64'(n_writes), 64'd0);
        chk("bad_hdr_write", 64'(ss_write), 64'd0);
        rdq.delete();

        // Slave never acks the read at addr 0
        clear_cfg();
        cfg_size[0] = 32'd2;
        block_addr0 = 1'b1; to_cnt = 0;
        got_q.delete();
        run_op("timeout", 1'b0, 1'b0);
        chk("timeout_cycles", 64'(to_cnt), 64'(TO));
        chk("timeout_error", 64'(error), 64'd1);
        chk("timeout_read", 64'(ss_read), 64'd0);
        block_addr0 = 1'b0;

        // Output stall of 20 cycles mid-save
        random_cfg();
        cfg_size[0] = 32'(MAXSZ);
        build_expected();
        got_q.delete();
        stall_arm = 1'b1; stall_reads = 0; hold_seen = 0; rand_lat = 1'b1;
        run_op("stall", 1'b0, 1'b0);
        chk("stall_error_cleared", 64'(error), 64'd0);
        chk("stall_held", 64'(hold_seen), 64'd20);
        chk("stall_reads_bounded", 64'(stall_reads <= FD), 64'd1);
        check_stream("stall");

        // Randomized save/restore rounds; one round raises both starts
        for (int r = 0; r < 4; r++) begin
            random_cfg();
            rand_lat = 1'b1; rand_wr = 1'b1; rand_rd = 1'b1;
            build_expected();
            got_q.delete();
            run_op($sformatf("rnd%0d_save", r), 1'b0, r == 2);
            chk($sformatf("rnd%0d_save_done", r), 64'(op_done), 64'd1);
            check_stream($sformatf("rnd%0d", r));
            restore_and_check($sformatf("rnd%0d_rest", r));
        end
        rand_lat = 1'b0; rand_wr = 1'b0; rand_rd = 1'b0;

`ifdef SS_SEQ_CHECKSUM_EN
        // Checksum trailer for data 1,2,3,4 and a corrupted restore
        clear_cfg();
        cfg_size[0] = 32'd4; cfg_width[0] = 8'd3;
        for (int a = 0; a < 4; a++) src[0][a] = 64'(a + 1);
        build_expected();
        got_q.delete();
        run_op("csum_save", 1'b0, 1'b0);
        chk("csum_trailer", (got_q.size() > 5) ? got_q[5] : 64'hx, 64'h0000_0000_0000_000A);
        rdq = got_q;
        rdq[2] = rdq[2] ^ 64'd1;
        run_op("csum_bad", 1'b1, 1'b0);
        chk("csum_bad_error", 64'(error), 64'd1);
        rdq.delete();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
